// File: rtl/relu_arbiter.sv
// relu_arbiter: NUM_CH valid/ready producers share one ReLU stage and
// one output register, granted round-robin. Negative words become zero.
// Ports: clk_i, reset_n_i (async, active-low);
//   valid_i/ready_o/data_i/last_i are the per-channel inputs;
//   valid_o/ready_i/data_r_o/ch_r_o/last_r_o are the registered output.
// Optional: define RELU_ARBITER_PKT_LOCK_EN to keep a channel granted
//   from its first beat until its last_i beat (packet locking).
module relu_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_CH    = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [NUM_CH-1:0]             valid_i,
    output logic [NUM_CH-1:0]             ready_o,
    input  logic [NUM_CH*WORD_SIZE-1:0]   data_i,
    input  logic [NUM_CH-1:0]             last_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [WORD_SIZE-1:0]          data_r_o,
    output logic [$clog2(NUM_CH)-1:0]     ch_r_o,
    output logic                          last_r_o
);

    localparam int CW = $clog2(NUM_CH);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   rr_ptr;
    logic [CW-1:0]   rr_nxt;
    logic [CW-1:0]   lock_ch;
    logic [CW-1:0]   lock_ch_nxt;
    logic [CW-1:0]   gnt;
    logic [CW-1:0]   sel;
    logic [CW-1:0]   sel_inc;
    logic [CW:0]     idx;
    logic            found;
    logic            slot_free;
    logic            accept;
    logic [WORD_SIZE-1:0] word;

    // Round-robin search: first valid channel at or after rr_ptr.
    // idx is one bit wider so the wrap works for any NUM_CH.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = {1'b0, rr_ptr} + (CW+1)'(i);
            if (idx >= (CW+1)'(NUM_CH)) begin
                idx = idx - (CW+1)'(NUM_CH);
            end
            if (!found && valid_i[idx[CW-1:0]]) begin
                found = 1'b1;
                gnt   = idx[CW-1:0];
            end
        end
    end

    assign slot_free = !valid_o || ready_i;
    assign sel       = (state == LOCKED) ? lock_ch : gnt;
    assign sel_inc   = (sel == CW'(NUM_CH - 1)) ? '0 : sel + CW'(1);
    assign word      = data_i[int'(sel)*WORD_SIZE +: WORD_SIZE];

    // Next state, pointer and handshake. A locked channel is offered
    // ready without looking at its valid_i.
    always_comb begin
        state_nxt   = state;
        lock_ch_nxt = lock_ch;
        rr_nxt      = rr_ptr;
        ready_o     = '0;
        if (reset_n_i && slot_free && (state == LOCKED || found)) begin
            ready_o[sel] = 1'b1;
        end
        accept = valid_i[sel] && ready_o[sel];
`ifdef RELU_ARBITER_PKT_LOCK_EN
        if (accept) begin
            unique case (state)
                IDLE: begin
                    if (!last_i[sel]) begin
                        state_nxt   = LOCKED;
                        lock_ch_nxt = sel;
                    end
                end
                LOCKED: begin
                    if (last_i[sel]) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
            if (last_i[sel]) begin
                rr_nxt = sel_inc;
            end
        end
`else
        if (accept) begin
            rr_nxt = sel_inc;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state   <= IDLE;
            lock_ch <= '0;
            rr_ptr  <= '0;
        end else begin
            state   <= state_nxt;
            lock_ch <= lock_ch_nxt;
            rr_ptr  <= rr_nxt;
        end
    end

    // Output register: drain and accept in one cycle keeps valid_o high.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid_o  <= 1'b0;
            data_r_o <= '0;
            ch_r_o   <= '0;
            last_r_o <= 1'b0;
        end else if (accept) begin
            valid_o  <= 1'b1;
            data_r_o <= word[WORD_SIZE-1] ? '0 : word;
            ch_r_o   <= sel;
            last_r_o <= last_i[sel];
        end else if (ready_i) begin
            valid_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_relu_arbiter.sv
// tb_relu_arbiter: directed and random stimulus for relu_arbiter,
// checked every cycle against a queue-free arithmetic reference model.
module tb_relu_arbiter;

    localparam int WS = 16;
    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NC-1:0] v;
    logic [NC-1:0] rdy_o;
    logic [NC*WS-1:0] d;
    logic [NC-1:0] l;
    logic          valid_o;
    logic          rdy;
    logic [WS-1:0] data_r_o;
    logic [1:0]    ch_r_o;
    logic          last_r_o;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    bit        m_valid;
    bit [15:0] m_data;
    int        m_ch;
    bit        m_last;
    int        m_rr;
    bit        m_locked;
    int        m_lock_ch;

    always #5 clk = ~clk;

    relu_arbiter #(.WORD_SIZE(WS), .NUM_CH(NC)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .valid_i   (v),
        .ready_o   (rdy_o),
        .data_i    (d),
        .last_i    (l),
        .valid_o   (valid_o),
        .ready_i   (rdy),
        .data_r_o  (data_r_o),
        .ch_r_o    (ch_r_o),
        .last_r_o  (last_r_o)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid   = 0;
        m_data    = 0;
        m_ch      = 0;
        m_last    = 0;
        m_rr      = 0;
        m_locked  = 0;
        m_lock_ch = 0;
    endtask

    function automatic int pick();
        if (m_locked) return m_lock_ch;
        for (int k = 0; k < NC; k++) begin
            if (v[(m_rr + k) % NC]) return (m_rr + k) % NC;
        end
        return -1;
    endfunction

    task automatic set_word(input int c, input logic [15:0] w);
        d[c*WS +: WS] = w;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_valid"}, valid_o, m_valid);
        check({tag, "_data"}, data_r_o, m_data);
        check({tag, "_ch"}, ch_r_o, m_ch);
        check({tag, "_last"}, last_r_o, m_last);
    endtask

    // One clock: check ready, apply the edge to the model, check outputs.
    task automatic cycle();
        int g;
        logic [NC-1:0] er;
        logic [15:0] w;
        #2;
        g  = pick();
        er = '0;
        if (rst_n && (!m_valid || rdy) && g >= 0) er[g] = 1'b1;
        check("ready_o", rdy_o, er);
        @(posedge clk);
        if (g >= 0 && er[g] && v[g]) begin
            w       = d[g*WS +: WS];
            m_data  = w[15] ? 16'h0 : w;
            m_ch    = g;
            m_last  = l[g];
            m_valid = 1;
`ifdef RELU_ARBITER_PKT_LOCK_EN
            if (!m_locked && !l[g]) begin
                m_locked  = 1;
                m_lock_ch = g;
            end else if (m_locked && l[g]) begin
                m_locked = 0;
            end
            if (l[g]) m_rr = (g + 1) % NC;
`else
            m_rr = (g + 1) % NC;
`endif
        end else if (rdy) begin
            m_valid = 0;
        end
        #1;
        check_outputs("out");
    endtask

    task automatic do_reset();
        rst_n = 0;
        v     = '0;
        l     = '0;
        rdy   = 0;
        @(posedge clk);
        #1;
        model_reset();
        check_outputs("rst");
        check("rst_ready", rdy_o, 4'h0);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        v     = '0;
        l     = '0;
        d     = '0;
        rdy   = 0;
        model_reset();
        do_reset();

        // negative word from ch0 becomes zero, one cycle latency
        v = 4'b0001;
        l = 4'hF;
        rdy = 1;
        set_word(0, 16'hFFF6);
        cycle();
        check("neg_valid", valid_o, 1);
        check("neg_data", data_r_o, 16'h0000);
        check("neg_ch", ch_r_o, 0);

        // ReLU boundary words
        set_word(0, 16'h0000);
        cycle();
        check("zero_data", data_r_o, 16'h0000);
        set_word(0, 16'h8000);
        cycle();
        check("min_data", data_r_o, 16'h0000);
        set_word(0, 16'h7FFF);
        cycle();
        check("max_data", data_r_o, 16'h7FFF);

        // all channels valid: rotation with no bubbles
        do_reset();
        v = 4'hF;
        l = 4'hF;
        rdy = 1;
        d = {$urandom, $urandom};
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("rr_ch", ch_r_o, i % NC);
            check("rr_valid", valid_o, 1);
        end

        // backpressure: beat held stable, next beat not lost
        v = 4'b0100;
        set_word(2, 16'h0123);
        cycle();
        check("bp_first", data_r_o, 16'h0123);
        rdy = 0;
        set_word(2, 16'h0456);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_hold_data", data_r_o, 16'h0123);
            check("bp_hold_ch", ch_r_o, 2);
            check("bp_hold_ready", rdy_o, 4'h0);
        end
        rdy = 1;
        cycle();
        check("bp_next_data", data_r_o, 16'h0456);
        check("bp_next_valid", valid_o, 1);

`ifdef RELU_ARBITER_PKT_LOCK_EN
        // ch1 packet of 3 beats holds the grant, then ch2
        do_reset();
        rdy = 1;
        v = 4'b0001;
        l = 4'hF;
        cycle();
        v = 4'b0111;
        l = 4'b0101;
        cycle();
        check("lock_b1", ch_r_o, 1);
        cycle();
        check("lock_b2", ch_r_o, 1);
        l = 4'b0111;
        cycle();
        check("lock_b3", ch_r_o, 1);
        check("lock_b3_last", last_r_o, 1);
        cycle();
        check("lock_after", ch_r_o, 2);
`endif

        // reset mid-packet with a held beat
        do_reset();
        rdy = 1;
        v = 4'b0010;
        l = 4'b0000;
        cycle();
        check("mid_valid", valid_o, 1);
        rst_n = 0;
        #1;
        check("mid_rst_valid", valid_o, 0);
        check("mid_rst_ready", rdy_o, 4'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        v = 4'hF;
        l = 4'hF;
        cycle();
        check("mid_first_ch", ch_r_o, 0);
        v = 4'b0100;
        cycle();
        check("mid_nolock_ch", ch_r_o, 2);

        // random traffic with occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            v   = 4'($urandom);
            l   = 4'($urandom) | 4'($urandom);
            d   = {$urandom, $urandom};
            rdy = ($urandom % 4) != 0;
            if ($urandom % 300 == 0) begin
                rst_n = 0;
                #1;
                check("rand_rst_valid", valid_o, 0);
                model_reset();
                @(posedge clk);
                #1;
                rst_n = 1;
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
